// File: rtl/md5_candidate_gen.sv
// Brute-force candidate generator for the md5core message interface.
// Optional CANDGEN_COUNT_EN adds a 64-bit valid-cycle counter output.
module md5_candidate_gen #(
  parameter int unsigned MIN_LEN = 1,
  parameter int unsigned MAX_LEN = 8,
  parameter logic [7:0]  CHAR_LO = 8'h61,
  parameter int unsigned RADIX   = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         en,
  output logic [447:0] message,
  output logic [63:0]  length,
  output logic         valid,
  output logic         busy,
  output logic         done
`ifdef CANDGEN_COUNT_EN
  ,
  output logic [63:0]  cand_count
`endif
);

  localparam int DW = (RADIX > 1) ? $clog2(RADIX) : 1;
  localparam int LW = $clog2(MAX_LEN + 2);
  localparam logic [DW-1:0] DMAX = DW'(RADIX - 1);
  localparam logic [LW-1:0] LMIN = LW'(MIN_LEN);
  localparam logic [LW-1:0] LMAX = LW'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0]  dig_q [MAX_LEN];
  logic [DW-1:0]  dig_d [MAX_LEN];
  logic [DW-1:0]  src   [MAX_LEN];
  logic [DW-1:0]  nxt   [MAX_LEN];
  logic [LW-1:0]  len_q, len_d;
  logic [LW-1:0]  src_len, nxt_len;
  logic [LW-1:0]  olen_q, olen_d;
  logic [447:0]   msg_q, msg_d, img;
  logic           valid_q, valid_d;
  logic           last_q, last_d;
  logic           ovf, load, emit;

  // A start outside RUN restarts the odometer at the first candidate
  always_comb begin
    load    = start && (state_q != S_RUN);
    src_len = load ? LMIN : len_q;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      src[i] = load ? '0 : dig_q[i];
    end
  end

  // Ripple-carry increment; rightmost active char is the fastest digit
  always_comb begin : adv
    logic cy;
    cy = 1'b1;
    for (int i = int'(MAX_LEN) - 1; i >= 0; i--) begin
      nxt[i] = src[i];
      if (cy && (i < int'(src_len))) begin
        if (src[i] == DMAX) begin
          nxt[i] = '0;
        end else begin
          nxt[i] = src[i] + 1'b1;
          cy     = 1'b0;
        end
      end
    end
    ovf     = cy;
    nxt_len = src_len;
    if (cy) begin
      nxt_len = src_len + 1'b1;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        nxt[i] = '0;
      end
    end
  end

  // Message image of the source candidate; unused bytes stay zero
  always_comb begin
    img = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if (i < int'(src_len)) begin
        img[447-8*i -: 8] = CHAR_LO + 8'(src[i]);
      end
    end
  end

  // Next-state and output register logic
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    len_d   = len_q;
    msg_d   = msg_q;
    olen_d  = olen_q;
    valid_d = 1'b0;
    last_d  = last_q;
    emit    = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          last_d  = 1'b0;
          dig_d   = src;
          len_d   = src_len;
          emit    = en;
        end
      end
      S_RUN: begin
        if (last_q) begin
          state_d = S_DONE;
          last_d  = 1'b0;
        end else begin
          emit = en;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (emit) begin
      msg_d   = img;
      olen_d  = src_len;
      valid_d = 1'b1;
      if (ovf && (src_len == LMAX)) begin
        last_d = 1'b1;
      end else begin
        dig_d = nxt;
        len_d = nxt_len;
      end
    end
  end

  // State, odometer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= LMIN;
      olen_q  <= '0;
      msg_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        dig_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      olen_q  <= olen_d;
      msg_q   <= msg_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        dig_q[i] <= dig_d[i];
      end
    end
  end

  assign message = msg_q;
  assign length  = 64'(olen_q) << 3;
  assign valid   = valid_q;
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);

`ifdef CANDGEN_COUNT_EN
  logic [63:0] cnt_q, cnt_d;

  // Valid cycles since the last accepted start
  always_comb begin
    cnt_d = load ? 64'd0 : cnt_q;
    if (valid_d) cnt_d = cnt_d + 64'd1;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cand_count = cnt_q;
`endif

endmodule

// File: tb/tb_md5_candidate_gen.sv
// Bench for md5_candidate_gen: small config scoreboard plus a
// default-parameter instance for the 27th-candidate check.
module tb_md5_candidate_gen;

  localparam int R    = 3;
  localparam int MINL = 1;
  localparam int MAXL = 2;
  localparam int TOT  = 12;

  typedef struct {
    logic [447:0] m;
    logic [63:0]  l;
  } cand_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, en;
  logic [447:0] message;
  logic [63:0]  length;
  logic         valid, busy, done;

  logic         d_rst, d_start, d_en;
  logic [447:0] d_message;
  logic [63:0]  d_length;
  logic         d_valid, d_busy, d_done;

`ifdef CANDGEN_COUNT_EN
  logic [63:0] cnt, d_cnt;
`endif

  md5_candidate_gen #(
    .MIN_LEN(MINL), .MAX_LEN(MAXL),
    .CHAR_LO(8'h61), .RADIX(R)
  ) u_small (
    .clk(clk), .rst(rst), .start(start), .en(en),
    .message(message), .length(length),
    .valid(valid), .busy(busy), .done(done)
`ifdef CANDGEN_COUNT_EN
    , .cand_count(cnt)
`endif
  );

  md5_candidate_gen u_def (
    .clk(clk), .rst(d_rst), .start(d_start), .en(d_en),
    .message(d_message), .length(d_length),
    .valid(d_valid), .busy(d_busy), .done(d_done)
`ifdef CANDGEN_COUNT_EN
    , .cand_count(d_cnt)
`endif
  );

  int    total = 0;
  int    bad   = 0;
  cand_t q[$];
  int    m_state = 0;
  int    m_k = 0;
  bit    m_last = 0;
  bit    m_valid = 0;
  int    nvalid = 0;
  int    d_nvalid = 0;

  task automatic chk(string tag, logic [447:0] obs, logic [447:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cand_t cand(int k);
    cand_t c;
    int r = k;
    int L;
    int p;
    c.m = '0;
    for (L = MINL; L <= MAXL; L++) begin
      p = 1;
      for (int j = 0; j < L; j++) p = p * R;
      if (r < p) break;
      r = r - p;
    end
    for (int i = L - 1; i >= 0; i--) begin
      c.m[447-8*i -: 8] = 8'h61 + 8'(r % R);
      r = r / R;
    end
    c.l = 64'(L * 8);
    return c;
  endfunction

  task automatic push();
    q.push_back(cand(m_k));
    m_k++;
    m_valid = 1;
    if (m_k == TOT) m_last = 1;
  endtask

  task automatic step();
    cand_t e;
    if (rst) begin
      m_state = 0; m_k = 0; m_last = 0; m_valid = 0;
      q.delete();
    end else begin
      m_valid = 0;
      case (m_state)
        0, 2: if (start) begin
          m_state = 1; m_k = 0; m_last = 0;
          if (en) push();
        end
        default: if (m_last) m_state = 2;
                 else if (en) push();
      endcase
    end
    @(posedge clk);
    #1;
    chk("valid", 448'(valid), 448'(m_valid));
    chk("busy", 448'(busy), 448'(m_state == 1));
    chk("done", 448'(done), 448'(m_state == 2));
    if (valid) begin
      nvalid++;
      if (q.size() == 0) begin
        chk("sb_empty", 448'(1), 448'(0));
      end else begin
        e = q.pop_front();
        chk("sb_msg", message, e.m);
        chk("sb_len", 448'(length), 448'(e.l));
      end
    end
    if (d_valid) d_nvalid++;
  endtask

  initial begin
    bit seen;
    rst = 1; start = 0; en = 0;
    d_rst = 1; d_start = 0; d_en = 0;
    step();
    step();
    chk("rst_msg", message, '0);
    chk("rst_len", 448'(length), 448'(0));
    chk("rst_dmsg", d_message, '0);
    chk("rst_dvalid", 448'(d_valid), 448'(0));
    rst = 0; d_rst = 0;
    step();

    // default params: 27th candidate is "aa"
    d_start = 1; d_en = 1;
    step();
    d_start = 0;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (d_nvalid == 27) begin
        seen = 1;
        chk("t3_hi", 448'(d_message[447:432]), 448'(16'h6161));
        chk("t3_rest", 448'(d_message[431:0]), 448'(0));
        chk("t3_len", 448'(d_length), 448'(64'h10));
        chk("t3_busy", 448'(d_busy), 448'(1));
        chk("t3_done", 448'(d_done), 448'(0));
`ifdef CANDGEN_COUNT_EN
        chk("t3_cnt", 448'(d_cnt), 448'(27));
`endif
      end else begin
        step();
      end
    end
    if (!seen) chk("t3_timeout", 448'(0), 448'(1));
    d_rst = 1;

    // full small enumeration
    nvalid = 0;
    start = 1; en = 1;
    step();
    start = 0;
    for (int c = 0; c < 40 && !done; c++) step();
    chk("t1_count", 448'(nvalid), 448'(TOT));
    chk("t1_last", 448'(message[447:432]), 448'(16'h6363));
    step();
    step();

    // en pause after "b"
    nvalid = 0;
    start = 1;
    step();
    start = 0;
    step();
    en = 0;
    step();
    chk("t2_hold1", 448'(message[447:440]), 448'(8'h62));
    step();
    chk("t2_hold2", 448'(message[447:440]), 448'(8'h62));
    en = 1;
    step();
    chk("t2_c", 448'(message[447:440]), 448'(8'h63));
    for (int c = 0; c < 40 && !done; c++) step();
    chk("t2_count", 448'(nvalid), 448'(TOT));

    // reset mid-run, then restart
    start = 1;
    step();
    start = 0;
    repeat (4) step();
    rst = 1;
    step();
    chk("t4_msg", message, '0);
    chk("t4_len", 448'(length), 448'(0));
    rst = 0; start = 1;
    step();
    start = 0;
    chk("t4_a", 448'(message[447:440]), 448'(8'h61));
    chk("t4_len8", 448'(length), 448'(8));

    // start in RUN ignored; start with rst loses
    step();
    start = 1;
    step();
    start = 0;
    step();
    rst = 1; start = 1;
    step();
    rst = 0; start = 0;
    step();
    chk("t5_msg", message, '0);

`ifdef CANDGEN_COUNT_EN
    start = 1; en = 1;
    step();
    start = 0;
    for (int c = 0; c < 40 && !done; c++) step();
    chk("t6_cnt_done", 448'(cnt), 448'(TOT));
    start = 1; en = 0;
    step();
    start = 0;
    chk("t6_cnt_clr", 448'(cnt), 448'(0));
    en = 1;
    step();
    chk("t6_cnt_one", 448'(cnt), 448'(1));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
